axi_riscv_aw_w_sync: RTL and testbench
======================================

Name: axi_riscv_aw_w_sync

Overview:
- Write-path ordering stage placed directly downstream of the LR/SC adapter's master port, in front of the memory-side AXI slave.
- Guarantees that no W beat is forwarded before its AW has been accepted downstream.
- Regenerates W LAST from the recorded AW LEN and flags beat-count mismatches.
- Covers handshake/control signals only. AW and W payload buses route around it unchanged, qualified by this block's valid/ready.

Parameters:
MAX_OUTSTANDING, 4, depth of the AW length FIFO (number of accepted AW bursts whose W beats are not yet complete); must be >= 1.
CNT_WIDTH, 8, width of the beat counter; fixed equal to the AXI LEN width.

Ports:
clk_i  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
slv_aw_valid_i  in  1  AW valid from upstream (LR/SC adapter)
slv_aw_ready_o  out  1  AW ready to upstream
slv_aw_len_i  in  8  AW burst length (beats-1)
mst_aw_valid_o  out  1  AW valid downstream
mst_aw_ready_i  in  1  AW ready from downstream
slv_w_valid_i  in  1  W valid from upstream
slv_w_ready_o  out  1  W ready to upstream
slv_w_last_i  in  1  upstream W LAST, checked only
mst_w_valid_o  out  1  W valid downstream
mst_w_ready_i  in  1  W ready from downstream
mst_w_last_o  out  1  regenerated W LAST
busy_o  out  1  at least one burst outstanding
err_last_o  out  1  one-cycle pulse on LAST mismatch

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk_i, rst_ni). While rst_ni=0, FIFO and beat_cnt are cleared and every output is 0.
- Reset mid-burst abandons all outstanding bursts; no recovery is attempted.
- State: LEN FIFO (depth MAX_OUTSTANDING, registered head), beat_cnt[7:0], error pulse register.
- AW path (combinational, no added latency):
  - mst_aw_valid_o = slv_aw_valid_i & !full.
  - slv_aw_ready_o = mst_aw_ready_i & !full.
  - On AW handshake (mst_aw_valid_o & mst_aw_ready_i), push slv_aw_len_i.
- Full: AW is blocked even when a pop occurs in the same cycle. There is no ready-through path from W to AW.
- W path:
  - mst_w_valid_o = slv_w_valid_i & !empty.
  - slv_w_ready_o = mst_w_ready_i & !empty.
  - mst_w_last_o = !empty & (beat_cnt == head_len).
- On W handshake:
  - If mst_w_last_o=1: pop FIFO, beat_cnt<=0.
  - Otherwise: beat_cnt<=beat_cnt+1.
  - beat_cnt never wraps because LEN <= 255.
- Latency: a W beat is forwarded no earlier than the cycle after its AW handshake. The FIFO is not fall-through by default.
- Push and pop in the same cycle: allowed when not full; occupancy is unchanged.
- Error check: err_last_o=1 for exactly one cycle after a W handshake where slv_w_last_i != mst_w_last_o. The beat is still forwarded using the regenerated LAST.
- busy_o = !empty.
- No protocol assumption on slv_w_valid_i before AW. Early W beats simply stall with ready=0.

Optional Feature:
- Macro: AXI_RISCV_AW_W_SYNC_FALLTHROUGH_EN.
- Defined: when the FIFO is empty and an AW handshake occurs, the W path treats the incoming slv_aw_len_i as head. A first W beat may pass in the same cycle as its AW, giving 0-cycle latency. A len=0 burst in that case completes without ever occupying the FIFO.
- Undefined: minimum 1-cycle AW-to-W latency as described in Behaviour.

Test Plan:
- Reset, then AW len=3 accepted, 4 W beats with correct last -> W forwarded from cycle after AW; mst_w_last_o=1 only on 4th beat; busy_o 1->0 after 4th beat; err_last_o=0.
- W valid asserted 5 cycles before AW -> slv_w_ready_o=0, mst_w_valid_o=0 until cycle after AW handshake.
- MAX_OUTSTANDING=4: 4 AWs len=0 with W held off -> 5th AW sees slv_aw_ready_o=0 even with mst_aw_ready_i=1; frees one cycle after first W beat pops.
- AW len=1, upstream drives slv_w_last_i=1 on 1st beat -> mst_w_last_o=0 on that beat, err_last_o pulses 1 cycle; 2nd beat gives last=1 and pop.
- Random backpressure on mst_aw_ready_i and mst_w_ready_i, 200 bursts len 0..15 -> downstream beat count per burst equals len+1, order preserved, no err.
- rst_ni asserted mid-burst (beat 2 of len=7) -> all outputs 0 immediately; after release busy_o=0 and the next AW len=0 completes normally. With FALLTHROUGH_EN: AW len=0 and W valid in the same cycle, FIFO empty -> both forwarded that cycle, busy_o stays 0.

Source files
------------

// File: rtl/axi_riscv_aw_w_sync.sv
// AW/W ordering stage: no W beat leaves before its AW is accepted downstream; W LAST is regenerated from AW LEN.
// AW path has no added latency; W waits 1 cycle after AW (0 with AXI_RISCV_AW_W_SYNC_FALLTHROUGH_EN); AW stalls when the LEN FIFO is full.
module axi_riscv_aw_w_sync #(
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_WIDTH       = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 slv_aw_valid_i,
  output logic                 slv_aw_ready_o,
  input  logic [CNT_WIDTH-1:0] slv_aw_len_i,
  output logic                 mst_aw_valid_o,
  input  logic                 mst_aw_ready_i,
  input  logic                 slv_w_valid_i,
  output logic                 slv_w_ready_o,
  input  logic                 slv_w_last_i,
  output logic                 mst_w_valid_o,
  input  logic                 mst_w_ready_i,
  output logic                 mst_w_last_o,
  output logic                 busy_o,
  output logic                 err_last_o
);

  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned OCC_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OCC_W-1:0] OCC_MAX  = OCC_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  logic [CNT_WIDTH-1:0] len_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W-1:0]     wr_ptr;
  logic [OCC_W-1:0]     occ;
  logic [CNT_WIDTH-1:0] beat_cnt;
  logic                 err_q;

  logic                 full;
  logic                 empty;
  logic                 aw_hs;
  logic                 w_avail;
  logic [CNT_WIDTH-1:0] head_len;
  logic                 w_hs;
  logic                 pop;
  logic                 do_push;
  logic                 do_pop;

  assign full  = (occ == OCC_MAX);
  assign empty = (occ == '0);

  // rst_ni gating keeps the pass-through AW outputs low while in reset
  assign mst_aw_valid_o = rst_ni & slv_aw_valid_i & ~full;
  assign slv_aw_ready_o = rst_ni & mst_aw_ready_i & ~full;
  assign aw_hs          = mst_aw_valid_o & mst_aw_ready_i;

`ifdef AXI_RISCV_AW_W_SYNC_FALLTHROUGH_EN
  assign w_avail  = ~empty | aw_hs;
  assign head_len = empty ? slv_aw_len_i : len_q[rd_ptr];
`else
  assign w_avail  = ~empty;
  assign head_len = len_q[rd_ptr];
`endif

  assign mst_w_valid_o = slv_w_valid_i & w_avail;
  assign slv_w_ready_o = mst_w_ready_i & w_avail;
  assign mst_w_last_o  = w_avail & (beat_cnt == head_len);
  assign w_hs          = mst_w_valid_o & mst_w_ready_i;
  assign pop           = w_hs & mst_w_last_o;

  // a burst that starts and ends while the FIFO is empty never enters it
  assign do_push = aw_hs & ~(empty & pop);
  assign do_pop  = pop & ~empty;

  assign busy_o     = ~empty;
  assign err_last_o = err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      occ      <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      occ <= occ + 1'b1;
      else if (!do_push && do_pop) occ <= occ - 1'b1;
      if (w_hs) beat_cnt <= mst_w_last_o ? '0 : beat_cnt + 1'b1;
      err_q <= w_hs & (slv_w_last_i != mst_w_last_o);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) len_q[wr_ptr] <= slv_aw_len_i;
  end

endmodule

// File: tb/tb_axi_riscv_aw_w_sync.sv
// Randomized bench for axi_riscv_aw_w_sync against a queue-based burst model.
module tb_axi_riscv_aw_w_sync;

  localparam int MAXO = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       slv_aw_valid, slv_aw_ready, mst_aw_valid, mst_aw_ready;
  logic [7:0] slv_aw_len;
  logic       slv_w_valid, slv_w_ready, slv_w_last;
  logic       mst_w_valid, mst_w_ready, mst_w_last;
  logic       busy, err_last;

  axi_riscv_aw_w_sync #(.MAX_OUTSTANDING(MAXO), .CNT_WIDTH(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .slv_aw_valid_i (slv_aw_valid),
    .slv_aw_ready_o (slv_aw_ready),
    .slv_aw_len_i   (slv_aw_len),
    .mst_aw_valid_o (mst_aw_valid),
    .mst_aw_ready_i (mst_aw_ready),
    .slv_w_valid_i  (slv_w_valid),
    .slv_w_ready_o  (slv_w_ready),
    .slv_w_last_i   (slv_w_last),
    .mst_w_valid_o  (mst_w_valid),
    .mst_w_ready_i  (mst_w_ready),
    .mst_w_last_o   (mst_w_last),
    .busy_o         (busy),
    .err_last_o     (err_last)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // model: queue of accepted burst lengths, beats done on the oldest one
  int q[$];
  int done_beats = 0;
  bit err_pend = 1'b0;
  bit m_aw_hs, m_w_hs;
  // scoreboard on what the DUT actually forwards downstream
  int sb[$];
  int obs_beats = 0;
  int sb_done = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    slv_aw_valid = 1'b0; slv_aw_len = 8'd0; mst_aw_ready = 1'b1;
    slv_w_valid  = 1'b0; slv_w_last = 1'b0; mst_w_ready  = 1'b1;
  endtask

  // Called just after a falling edge with inputs set; checks, updates model, waits next falling edge.
  task automatic cycle();
    bit full, empty, avail, e_last;
    int head;
    #1;
    m_aw_hs = 1'b0; m_w_hs = 1'b0;
    if (!rst_n) begin
      q.delete(); sb.delete();
      done_beats = 0; err_pend = 1'b0; obs_beats = 0;
      chk("rst_mst_aw_valid", mst_aw_valid, 0);
      chk("rst_slv_aw_ready", slv_aw_ready, 0);
      chk("rst_mst_w_valid",  mst_w_valid,  0);
      chk("rst_slv_w_ready",  slv_w_ready,  0);
      chk("rst_mst_w_last",   mst_w_last,   0);
      chk("rst_busy",         busy,         0);
      chk("rst_err_last",     err_last,     0);
    end else begin
      full  = (q.size() == MAXO);
      empty = (q.size() == 0);
      m_aw_hs = slv_aw_valid && mst_aw_ready && !full;
      avail = !empty;
      head  = empty ? 0 : q[0];
`ifdef AXI_RISCV_AW_W_SYNC_FALLTHROUGH_EN
      if (empty && m_aw_hs) begin
        avail = 1'b1;
        head  = int'(slv_aw_len);
      end
`endif
      e_last = avail && (done_beats == head);
      chk("mst_aw_valid", mst_aw_valid, slv_aw_valid && !full);
      chk("slv_aw_ready", slv_aw_ready, mst_aw_ready && !full);
      chk("mst_w_valid",  mst_w_valid,  slv_w_valid && avail);
      chk("slv_w_ready",  slv_w_ready,  mst_w_ready && avail);
      chk("mst_w_last",   mst_w_last,   e_last);
      chk("busy",         busy,         !empty);
      chk("err_last",     err_last,     err_pend);
      m_w_hs = slv_w_valid && mst_w_ready && avail;
      if (m_aw_hs) begin
        q.push_back(int'(slv_aw_len));
        sb.push_back(int'(slv_aw_len));
      end
      if (mst_w_valid && mst_w_ready) begin
        obs_beats++;
        if (mst_w_last) begin
          if (sb.size() == 0) chk("burst_without_aw", obs_beats, 0);
          else chk("burst_beats", obs_beats - 1, sb.pop_front());
          obs_beats = 0;
          sb_done++;
        end
      end
      err_pend = m_w_hs && (slv_w_last != e_last);
      if (m_w_hs) begin
        if (e_last) begin
          void'(q.pop_front());
          done_beats = 0;
        end else begin
          done_beats++;
        end
      end
    end
    @(negedge clk);
  endtask

  int wq[$];
  int w_beat;
  int aw_left;

  initial begin
    rst_n = 1'b0;
    idle();
    slv_aw_valid = 1'b1; slv_w_valid = 1'b1; slv_aw_len = 8'd5;
    @(negedge clk);
    cycle(); cycle();
    rst_n = 1'b1;
    idle();
    cycle();

    // W valid well ahead of AW, then len=3 burst with correct LAST
    slv_w_valid = 1'b1;
    repeat (5) cycle();
    slv_aw_valid = 1'b1; slv_aw_len = 8'd3;
    cycle();
    slv_aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      slv_w_last = (i == 3);
      cycle();
    end
    idle();
    cycle();
    chk("busy_after_first_burst", busy, 0);

    // fill the FIFO with len=0 bursts, W held off; 5th AW must stall until a pop
    for (int i = 0; i < MAXO + 2; i++) begin
      slv_aw_valid = 1'b1; slv_aw_len = 8'd0;
      cycle();
    end
    slv_w_valid = 1'b1; slv_w_last = 1'b1;
    cycle();
    cycle();
    slv_aw_valid = 1'b0;
    repeat (MAXO + 2) cycle();
    idle();
    cycle();

    // len=1 with LAST wrongly asserted on the first beat
    slv_aw_valid = 1'b1; slv_aw_len = 8'd1;
    cycle();
    slv_aw_valid = 1'b0;
    slv_w_valid = 1'b1; slv_w_last = 1'b1;
    cycle();
    cycle();
    idle();
    cycle();
    cycle();

    // random backpressure, 200 bursts of len 0..15
    sb_done = 0; w_beat = 0; aw_left = 200;
    for (int c = 0; c < 20000 && sb_done < 200; c++) begin
      if (!slv_aw_valid && aw_left > 0 && $urandom_range(0, 2) != 0) begin
        slv_aw_valid = 1'b1;
        slv_aw_len   = 8'($urandom_range(0, 15));
        wq.push_back(int'(slv_aw_len));
        aw_left--;
      end
      mst_aw_ready = ($urandom_range(0, 3) != 0);
      mst_w_ready  = ($urandom_range(0, 3) != 0);
      if (!slv_w_valid && wq.size() > 0 && $urandom_range(0, 3) != 0) slv_w_valid = 1'b1;
      slv_w_last = (wq.size() > 0) && (w_beat == wq[0]);
      cycle();
      if (m_aw_hs) slv_aw_valid = 1'b0;
      if (m_w_hs) begin
        if (w_beat == wq[0]) begin
          void'(wq.pop_front());
          w_beat = 0;
        end else begin
          w_beat++;
        end
        slv_w_valid = 1'b0;
      end
    end
    chk("random_bursts_completed", sb_done, 200);
    idle();
    cycle();

    // reset in the middle of a len=7 burst
    slv_aw_valid = 1'b1; slv_aw_len = 8'd7;
    cycle();
    slv_aw_valid = 1'b0;
    slv_w_valid = 1'b1; slv_w_last = 1'b0;
    cycle(); cycle();
    slv_aw_valid = 1'b1;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    idle();
    cycle();
    chk("busy_after_reset", busy, 0);
    slv_aw_valid = 1'b1; slv_aw_len = 8'd0;
    cycle();
    slv_aw_valid = 1'b0;
    slv_w_valid = 1'b1; slv_w_last = 1'b1;
    cycle();
    idle();
    cycle();
    chk("busy_after_post_reset_burst", busy, 0);

`ifdef AXI_RISCV_AW_W_SYNC_FALLTHROUGH_EN
    // AW len=0 and its only W beat in the same cycle on an empty FIFO
    slv_aw_valid = 1'b1; slv_aw_len = 8'd0;
    slv_w_valid = 1'b1; slv_w_last = 1'b1;
    cycle();
    idle();
    cycle();
    chk("ft_busy", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
